// File: rtl/rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter_if
// Purpose  : Two-port ROM request/response bundle plus the shared ROM
//            address/data pair.
// Revision : 1.0 - initial release
// ============================================================================
interface rom_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Port A (instruction fetch)
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic              gnt_a;
  logic              rvalid_a;
  logic [DATA_W-1:0] rdata_a;
  // Port B (data load)
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic              gnt_b;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata_b;
  // Shared combinational ROM
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;

  // Requester side: both fetch and load masters
  modport master (
    output req_a, addr_a, req_b, addr_b,
    input  gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b
  );

  // Arbiter side
  modport slave (
    input  req_a, addr_a, req_b, addr_b, rom_dout,
    output gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b, rom_addr
  );

  // ROM side
  modport rom (
    input  rom_addr,
    output rom_dout
  );
endinterface : rom_arbiter_if
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter
// Purpose  : Round-robin arbiter sharing one combinational ROM between an
//            instruction-fetch port (A) and a data-load port (B). One access
//            per cycle, response one cycle after the grant.
// Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  rom_arbiter_if.slave   bus
);

  // Most recently granted port; LAST_B after reset so A wins first contention
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  last_e             last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rvalid_a_q;
  logic              rvalid_b_q;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  logic              gnt_a;
  logic              gnt_b;

  // Grant decision: a lone requester always wins, contention goes to the
  // port that was not served last. Nothing is granted while in reset.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (bus.req_a && (!bus.req_b || (last_q == LAST_B))) begin
        gnt_a = 1'b1;
      end else if (bus.req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  // ROM address follows the granted port; idle cycles replay the previous
  // granted address so the ROM input never wanders to unrelated values.
  always_comb begin
    if (gnt_a) begin
      bus.rom_addr = bus.addr_a;
    end else if (gnt_b) begin
      bus.rom_addr = bus.addr_b;
    end else begin
      bus.rom_addr = addr_q;
    end
  end

  // Arbitration state, held address and per-port response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= LAST_B;
      addr_q     <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      rvalid_a_q <= gnt_a;
      rvalid_b_q <= gnt_b;
      if (gnt_a) begin
        last_q    <= LAST_A;
        addr_q    <= bus.addr_a;
        rdata_a_q <= bus.rom_dout;
      end else if (gnt_b) begin
        last_q    <= LAST_B;
        addr_q    <= bus.addr_b;
        rdata_b_q <= bus.rom_dout;
      end
    end
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;

endmodule : rom_arbiter
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_arbiter
// Purpose  : Self-checking bench for rom_arbiter: directed scenarios plus a
//            randomized run against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ROM
  logic [DATA_W-1:0] rom [0:DEPTH-1];
  assign bus.rom_dout = rom[bus.rom_addr];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int                m_last;     // 0: A served last, 1: B served last
  bit                m_pend_a, m_pend_b;
  logic [DATA_W-1:0] m_pdata_a, m_pdata_b;
  logic [DATA_W-1:0] m_rdata_a, m_rdata_b;
  logic [ADDR_W-1:0] m_addr;
  int                m_wait_a, m_wait_b;
  int                gnt_hist[$];

  task automatic model_reset();
    m_last    = 1;
    m_pend_a  = 0;
    m_pend_b  = 0;
    m_pdata_a = '0;
    m_pdata_b = '0;
    m_rdata_a = '0;
    m_rdata_b = '0;
    m_addr    = '0;
    m_wait_a  = 0;
    m_wait_b  = 0;
  endtask

  task automatic drive(input bit ra, input int aa, input bit rb, input int ab);
    bus.req_a  = ra;
    bus.addr_a = aa[ADDR_W-1:0];
    bus.req_b  = rb;
    bus.addr_b = ab[ADDR_W-1:0];
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Called at the falling edge: compare the DUT against the model for this
  // cycle, then let the model take the cycle's grant.
  task automatic sample(input string tag);
    bit                eg_a, eg_b;
    logic [ADDR_W-1:0] eaddr;
    @(negedge clk);
    if (m_pend_a) m_rdata_a = m_pdata_a;
    if (m_pend_b) m_rdata_b = m_pdata_b;
    if (bus.req_a && bus.req_b) begin
      eg_a = (m_last == 1);
      eg_b = !eg_a;
    end else begin
      eg_a = bus.req_a;
      eg_b = bus.req_b;
    end
    eaddr = eg_a ? bus.addr_a : (eg_b ? bus.addr_b : m_addr);

    n_cmp++;
    if (bus.gnt_a !== eg_a) begin
      n_err++;
      $display("FAIL %s gnt_a: got %b want %b", tag, bus.gnt_a, eg_a);
    end
    n_cmp++;
    if (bus.gnt_b !== eg_b) begin
      n_err++;
      $display("FAIL %s gnt_b: got %b want %b", tag, bus.gnt_b, eg_b);
    end
    n_cmp++;
    if (bus.rom_addr !== eaddr) begin
      n_err++;
      $display("FAIL %s rom_addr: got %0d want %0d", tag, bus.rom_addr, eaddr);
    end
    n_cmp++;
    if (bus.rvalid_a !== m_pend_a) begin
      n_err++;
      $display("FAIL %s rvalid_a: got %b want %b", tag, bus.rvalid_a, m_pend_a);
    end
    n_cmp++;
    if (bus.rvalid_b !== m_pend_b) begin
      n_err++;
      $display("FAIL %s rvalid_b: got %b want %b", tag, bus.rvalid_b, m_pend_b);
    end
    n_cmp++;
    if (bus.rdata_a !== m_rdata_a) begin
      n_err++;
      $display("FAIL %s rdata_a: got %h want %h", tag, bus.rdata_a, m_rdata_a);
    end
    n_cmp++;
    if (bus.rdata_b !== m_rdata_b) begin
      n_err++;
      $display("FAIL %s rdata_b: got %h want %h", tag, bus.rdata_b, m_rdata_b);
    end
    n_cmp++;
    if ((bus.gnt_a && bus.gnt_b) || (bus.rvalid_a && bus.rvalid_b)) begin
      n_err++;
      $display("FAIL %s exclusive: gnt %b%b rvalid %b%b want at most one each",
               tag, bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b);
    end
    // Starvation bound, measured on the DUT's own grants
    m_wait_a = (bus.req_a && !bus.gnt_a) ? m_wait_a + 1 : 0;
    m_wait_b = (bus.req_b && !bus.gnt_b) ? m_wait_b + 1 : 0;
    n_cmp++;
    if (m_wait_a > 1 || m_wait_b > 1) begin
      n_err++;
      $display("FAIL %s max_wait: got a=%0d b=%0d want <=1", tag, m_wait_a, m_wait_b);
    end
    gnt_hist.push_back((bus.gnt_a ? 1 : 0) + (bus.gnt_b ? 2 : 0));

    m_pend_a = eg_a;
    m_pend_b = eg_b;
    if (eg_a) begin
      m_pdata_a = rom[bus.addr_a];
      m_last    = 0;
    end
    if (eg_b) begin
      m_pdata_b = rom[bus.addr_b];
      m_last    = 1;
    end
    m_addr = eaddr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    advance();
    advance();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1, 5, 1, 6);
    @(negedge clk);
    n_cmp++;
    if (bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_gnt: got %b%b want 00", bus.gnt_a, bus.gnt_b);
    end
    n_cmp++;
    if (bus.rvalid_a !== 1'b0 || bus.rvalid_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rvalid: got %b%b want 00", bus.rvalid_a, bus.rvalid_b);
    end
    n_cmp++;
    if (bus.rdata_a !== '0 || bus.rdata_b !== '0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", bus.rdata_a, bus.rdata_b);
    end
    n_cmp++;
    if (bus.rom_addr !== '0) begin
      n_err++;
      $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr);
    end
    do_reset();
  endtask

  task automatic test_single_a();
    do_reset();
    drive(1, 0, 0, 0);
    sample("single_a_req");
    advance();
    drive(0, 0, 0, 0);
    sample("single_a_rsp");
    n_cmp++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 32'h00000193 || bus.rvalid_b !== 1'b0) begin
      n_err++;
      $display("FAIL single_a: got rvalid_a=%b rdata_a=%h rvalid_b=%b want 1 00000193 0",
               bus.rvalid_a, bus.rdata_a, bus.rvalid_b);
    end
    advance();
  endtask

  task automatic test_contention();
    int want[4] = '{1, 2, 1, 2};
    do_reset();
    gnt_hist.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 2);
      sample("contention");
      if (i == 1) begin
        n_cmp++;
        if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 32'h00a00393) begin
          n_err++;
          $display("FAIL contention_rsp_a: got %b %h want 1 00a00393", bus.rvalid_a, bus.rdata_a);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 32'h00818413) begin
          n_err++;
          $display("FAIL contention_rsp_b: got %b %h want 1 00818413", bus.rvalid_b, bus.rdata_b);
        end
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gnt_hist[i] !== want[i]) begin
        n_err++;
        $display("FAIL contention_order[%0d]: got %0d want %0d", i, gnt_hist[i], want[i]);
      end
    end
    drive(0, 0, 0, 0);
    sample("contention_tail");
    advance();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] fib [4];
    int rv_cnt = 0;
    int ga_cnt = 0;
    fib[0] = 32'h00000193;
    fib[1] = 32'h00a00393;
    fib[2] = 32'h00818413;
    fib[3] = 32'h00418493;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(0, 0, 1, i);
      else       drive(0, 0, 0, 0);
      sample("b2b");
      if (bus.gnt_a) ga_cnt++;
      if (i > 0) begin
        if (bus.rvalid_b) rv_cnt++;
        n_cmp++;
        if (bus.rdata_b !== fib[i-1]) begin
          n_err++;
          $display("FAIL b2b_word[%0d]: got %h want %h", i - 1, bus.rdata_b, fib[i-1]);
        end
      end
      advance();
    end
    n_cmp++;
    if (rv_cnt !== 4 || ga_cnt !== 0) begin
      n_err++;
      $display("FAIL b2b_count: got rvalid_b=%0d gnt_a=%0d want 4 0", rv_cnt, ga_cnt);
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    drive(1, 0, 0, 0);
    sample("mid_reset_req");
    advance();
    drive(0, 0, 0, 0);
    #1;
    n_cmp++;
    if (bus.rvalid_a !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_pre: got rvalid_a=%b want 1", bus.rvalid_a);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.rvalid_a !== 1'b0 || bus.rdata_a !== '0) begin
      n_err++;
      $display("FAIL mid_reset_clear: got rvalid_a=%b rdata_a=%h want 0 0", bus.rvalid_a, bus.rdata_a);
    end
    model_reset();
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample("mid_reset_after");
      n_cmp++;
      if (bus.rvalid_a !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reset_no_pulse: got rvalid_a=%b want 0", bus.rvalid_a);
      end
      advance();
    end
  endtask

  task automatic test_drop();
    do_reset();
    drive(1, 0, 0, 0);
    sample("drop_prime");
    advance();
    drive(0, 0, 0, 0);
    sample("drop_prime_rsp");
    advance();
    drive(1, 2, 1, 3);
    sample("drop_contend");
    n_cmp++;
    if (bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b1) begin
      n_err++;
      $display("FAIL drop_contend: got gnt=%b%b want 01", bus.gnt_a, bus.gnt_b);
    end
    advance();
    drive(0, 0, 0, 0);
    sample("drop_after");
    n_cmp++;
    if (bus.rvalid_a !== 1'b0 || bus.rdata_a !== 32'h00000193) begin
      n_err++;
      $display("FAIL drop_no_rsp: got rvalid_a=%b rdata_a=%h want 0 00000193", bus.rvalid_a, bus.rdata_a);
    end
    advance();
    sample("drop_idle");
    advance();
  endtask

  task automatic test_random();
    bit hold_a = 0;
    bit hold_b = 0;
    bit ra, rb;
    int aa, ab;
    do_reset();
    aa = 0;
    ab = 0;
    for (int i = 0; i < 1000; i++) begin
      // Ungranted requesters keep req/addr stable
      if (hold_a) ra = 1;
      else begin
        ra = ($urandom_range(0, 2) != 0);
        aa = $urandom_range(0, DEPTH - 1);
      end
      if (hold_b) rb = 1;
      else begin
        rb = ($urandom_range(0, 2) != 0);
        ab = $urandom_range(0, DEPTH - 1);
      end
      drive(ra, aa, rb, ab);
      sample("random");
      hold_a = bus.req_a && !bus.gnt_a;
      hold_b = bus.req_b && !bus.gnt_b;
      advance();
    end
    drive(0, 0, 0, 0);
    sample("random_tail");
    advance();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[0] = 32'h00000193;
    rom[1] = 32'h00a00393;
    rom[2] = 32'h00818413;
    rom[3] = 32'h00418493;
    drive(0, 0, 0, 0);
    model_reset();

    test_reset();
    test_single_a();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    test_drop();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rom_arbiter
`default_nettype wire

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, ROM address width (1024 words).
REQ-002 Parameter DATA_W, default 32, ROM word width.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 req_a  input  1  port A (instruction fetch) request; held high until granted.
REQ-006 addr_a  input  ADDR_W  port A word address; stable while req_a high.
REQ-007 gnt_a  output  1  port A request accepted this cycle.
REQ-008 rvalid_a  output  1  port A read data valid, one-cycle pulse.
REQ-009 rdata_a  output  DATA_W  port A read data.
REQ-010 req_b, addr_b, gnt_b, rvalid_b, rdata_b: port B (data load) signals, same widths and meaning as port A.
REQ-011 rom_addr  output  ADDR_W  address driven to the shared combinational ROM.
REQ-012 rom_dout  input  DATA_W  ROM read data, combinational from rom_addr.

Function
REQ-013 The block shall serve at most one ROM access per cycle, shared between ports A and B.
REQ-014 Arbitration state shall be a 2-state register LAST in {LAST_A, LAST_B} recording the most recently granted port.
REQ-015 If exactly one of req_a/req_b is high, that port shall be granted in the same cycle, whatever LAST is.
REQ-016 If both are high, the port not recorded in LAST shall be granted (round-robin): LAST_B -> grant A, LAST_A -> grant B.
REQ-017 gnt_a/gnt_b shall be combinational from req_a, req_b and LAST, mutually exclusive, and never high without the matching req.
REQ-018 rom_addr shall equal addr of the granted port; with no grant it shall equal the last granted address (no glitching to unrelated values).
REQ-019 On a rising edge with a grant, LAST shall update to the granted port; with no grant LAST shall hold.
REQ-020 Read latency: gnt_x in cycle N -> rvalid_x high in cycle N+1 only, rdata_x = rom_dout sampled at end of cycle N.
REQ-021 rdata_x shall hold its last value until the next response to that port; the other port's rdata is unaffected.
REQ-022 rvalid_a and rvalid_b shall never be high in the same cycle.
REQ-023 A requester not granted shall keep req/addr stable; the block shall not latch a request without granting it.
REQ-024 Back-to-back grants to one port (req held, other idle) shall yield one response per cycle, full throughput.
REQ-025 Under continuous contention each port shall receive exactly every second grant (no starvation, max wait 1 cycle).
REQ-026 A request dropped before grant (req falls) shall produce no response.

Reset
REQ-027 While RESET_N low: LAST = LAST_B (port A wins first contention), rvalid_a = rvalid_b = 0, rdata_a = rdata_b = 0, stored rom_addr = 0.
REQ-028 Reset assertion mid-access shall clear any pending rvalid immediately (asynchronously); no response for the interrupted grant after release.
REQ-029 gnt outputs shall be 0 while RESET_N is low regardless of req inputs.
REQ-030 First rising edge after RESET_N release shall behave as a normal arbitration cycle.

Verification (ROM loaded with fibonacci program: word0 = 32'h00000193, word1 = 32'h00a00393, word2 = 32'h00818413, word3 = 32'h00418493)
REQ-031 Reset, then req_a=1 addr_a=0 one cycle -> gnt_a same cycle, next cycle rvalid_a=1 rdata_a=32'h00000193, rvalid_b=0.
REQ-032 req_a and req_b both high after reset, addr_a=1, addr_b=2, held 4 cycles -> grants A,B,A,B; responses rdata_a=32'h00a00393, rdata_b=32'h00818413 on alternating cycles.
REQ-033 req_b held alone, addr_b stepping 0..3 each cycle -> rvalid_b high 4 consecutive cycles with words 0..3 in order, gnt_a never high.
REQ-034 req_a granted in cycle N, RESET_N pulsed low in cycle N+1 before the edge -> rvalid_a 0 immediately, rdata_a = 0, no pulse after release.
REQ-035 req_a raised then dropped in a cycle where port B wins contention -> no rvalid_a; rdata_a retains prior value (32'h00000193 from REQ-031 sequence).
REQ-036 Random req/addr for 1000 cycles vs. reference model -> grants mutually exclusive, every grant yields exactly one correct response one cycle later, max wait 1 cycle.
